// File: rtl/mac_accumulator.sv
//------------------------------------------------------------------------------
// mac_accumulator: sums N_TERMS unsigned products per frame, valid/ready out.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mac_accumulator #(
    parameter int N_BITS   = 4,
    parameter int N_TERMS  = 8,
    parameter int ACC_BITS = 11
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [2*N_BITS-1:0]                product,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [ACC_BITS-1:0]                acc_out,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               busy,
    output logic [$clog2(N_TERMS+1)-1:0]       term_cnt
);

    localparam int C_PROD_W = 2 * N_BITS;
    localparam int C_CNT_W  = $clog2(N_TERMS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    logic [ACC_BITS-1:0]   r_acc;
    logic [C_CNT_W-1:0]    r_cnt;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_busy;

    logic [ACC_BITS-1:0]   w_prod_ext;
    logic                  w_last;

    assign w_prod_ext = {{(ACC_BITS - C_PROD_W){1'b0}}, product};
    assign w_last     = (r_cnt == C_CNT_W'(N_TERMS - 1));

    // Handshake flags are registered alongside the state so no input reaches an output combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_ACCUM;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (in_valid) begin
                        r_acc <= r_acc + w_prod_ext;
                        r_cnt <= r_cnt + C_CNT_W'(1);
                        if (w_last) begin
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (start) begin
                            r_state    <= S_ACCUM;
                            r_acc      <= '0;
                            r_cnt      <= '0;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign acc_out   = r_acc;
    assign term_cnt  = r_cnt;

endmodule

`default_nettype wire
